// File: rtl/if_id_stage_if.sv
// Bundle between the fetch stage and the hazard/branch logic plus instruction memory.
// The slave side is the fetch stage itself.
interface if_id_stage_if;
    logic        Stall;
    logic        Flush;
    logic        Redirect;
    logic [31:0] RedirectAddr;
    logic [31:0] ImemAddr;
    logic [31:0] ImemData;
    logic [31:0] PC;
    logic [31:0] IFID_Instr;
    logic [31:0] IFID_PCPlus4;
    logic        IFID_Valid;
    logic [5:0]  Opcode;
    logic [4:0]  Rs;
    logic [4:0]  Rt;
    logic [4:0]  Rd;
    logic [4:0]  Shamt;
    logic [5:0]  Funct;
    logic [15:0] Imm16;
    logic [25:0] JumpIndex;
    logic [31:0] FetchCount;

    modport master (
        output Stall, Flush, Redirect, RedirectAddr, ImemData,
        input  ImemAddr, PC, IFID_Instr, IFID_PCPlus4, IFID_Valid, Opcode, Rs, Rt, Rd,
               Shamt, Funct, Imm16, JumpIndex, FetchCount
    );

    modport slave (
        input  Stall, Flush, Redirect, RedirectAddr, ImemData,
        output ImemAddr, PC, IFID_Instr, IFID_PCPlus4, IFID_Valid, Opcode, Rs, Rt, Rd,
               Shamt, Funct, Imm16, JumpIndex, FetchCount
    );
endinterface

// File: rtl/if_id_stage.sv
// Instruction fetch stage: PC register, IF/ID pipeline register, field decode and a
// count of valid instructions accepted into IF/ID.
module if_id_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input logic         Clk,
    input logic         Reset,
    if_id_stage_if.slave bus
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pcp4_q, pcp4_d;
    logic        valid_q, valid_d;
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] pc_plus4;
    logic        unused_redirect_lsb;

    assign pc_plus4 = pc_q + 32'd4;
    // Targets are word aligned; the low address bits are dropped on purpose.
    assign unused_redirect_lsb = ^bus.RedirectAddr[1:0];

    always_comb begin
        pc_d        = pc_plus4;
        instr_d     = instr_q;
        pcp4_d      = pcp4_q;
        valid_d     = valid_q;
        fetch_cnt_d = fetch_cnt_q;

        if (bus.Redirect) begin
            pc_d = {bus.RedirectAddr[31:2], 2'b00};
        end else if (bus.Stall) begin
            pc_d = pc_q;
        end

        if (bus.Flush || bus.Redirect) begin
            instr_d = 32'd0;
            pcp4_d  = 32'd0;
            valid_d = 1'b0;
        end else if (!bus.Stall) begin
            instr_d     = bus.ImemData;
            pcp4_d      = pc_plus4;
            valid_d     = 1'b1;
            fetch_cnt_d = fetch_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            pc_q        <= {RESET_PC[31:2], 2'b00};
            instr_q     <= 32'd0;
            pcp4_q      <= 32'd0;
            valid_q     <= 1'b0;
            fetch_cnt_q <= 32'd0;
        end else begin
            pc_q        <= pc_d;
            instr_q     <= instr_d;
            pcp4_q      <= pcp4_d;
            valid_q     <= valid_d;
            fetch_cnt_q <= fetch_cnt_d;
        end
    end

    assign bus.ImemAddr     = pc_q;
    assign bus.PC           = pc_q;
    assign bus.IFID_Instr   = instr_q;
    assign bus.IFID_PCPlus4 = pcp4_q;
    assign bus.IFID_Valid   = valid_q;
    assign bus.FetchCount   = fetch_cnt_q;

    // A bubble holds an all-zero word, so every field reads as sll $0,$0,0.
    assign bus.Opcode    = instr_q[31:26];
    assign bus.Rs        = instr_q[25:21];
    assign bus.Rt        = instr_q[20:16];
    assign bus.Rd        = instr_q[15:11];
    assign bus.Shamt     = instr_q[10:6];
    assign bus.Funct     = instr_q[5:0];
    assign bus.Imm16     = instr_q[15:0];
    assign bus.JumpIndex = instr_q[25:0];

endmodule

// File: tb/tb_if_id_stage.sv
// Self-checking bench for if_id_stage: directed scenarios plus randomized control
// traffic compared against a behavioural pipeline model.
module tb_if_id_stage;

    logic Clk;
    logic Reset;
    int   n_cmp;
    int   n_bad;

    if_id_stage_if bus ();

    if_id_stage #(.RESET_PC(32'h0000_0000)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic logic [31:0] imem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h2008_0005;
        if (a == 32'h4) return 32'h2009_FFFF;
        return {a[15:0] ^ 16'hC3A5, a[31:16] ^ ~a[15:0]};
    endfunction

    assign bus.ImemData = imem_word(bus.ImemAddr);

    // Reference model of the architecturally visible state.
    logic [31:0] m_pc, m_instr, m_pcp4, m_cnt;
    logic        m_valid;

    task automatic model_reset();
        m_pc = 32'h0; m_instr = 32'h0; m_pcp4 = 32'h0; m_valid = 1'b0; m_cnt = 32'h0;
    endtask

    task automatic do_reset();
        Reset = 1'b0;
        #1;
        Reset = 1'b1;
        model_reset();
    endtask

    // Apply controls for one edge, advance the model, then sample 1 time unit after the edge.
    task automatic step(input logic s, input logic f, input logic r, input logic [31:0] ra);
        logic [31:0] fetched;
        bus.Stall = s; bus.Flush = f; bus.Redirect = r; bus.RedirectAddr = ra;
        fetched = imem_word(m_pc);
        if (f || r) begin
            m_instr = 32'h0; m_pcp4 = 32'h0; m_valid = 1'b0;
        end else if (!s) begin
            m_instr = fetched; m_pcp4 = m_pc + 32'd4; m_valid = 1'b1; m_cnt = m_cnt + 32'd1;
        end
        if (r) m_pc = {ra[31:2], 2'b00};
        else if (!s) m_pc = m_pc + 32'd4;
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        n_cmp++; if (bus.PC !== 32'h0) begin n_bad++;
            $display("FAIL reset_pc: got %h want %h", bus.PC, 32'h0); end
        n_cmp++; if (bus.IFID_Valid !== 1'b0) begin n_bad++;
            $display("FAIL reset_valid: got %b want 0", bus.IFID_Valid); end
        n_cmp++; if (bus.IFID_Instr !== 32'h0) begin n_bad++;
            $display("FAIL reset_instr: got %h want 0", bus.IFID_Instr); end
        @(posedge Clk); #1;
        do_reset();
        step(0, 0, 0, 32'h0);
        step(0, 0, 1, 32'h40);
        n_cmp++; if (bus.PC !== 32'h40) begin n_bad++;
            $display("FAIL pre_reset_pc: got %h want %h", bus.PC, 32'h40); end
        Reset = 1'b0;
        #1;
        n_cmp++; if (bus.PC !== 32'h0) begin n_bad++;
            $display("FAIL async_reset_pc: got %h want 0", bus.PC); end
        n_cmp++; if (bus.IFID_Valid !== 1'b0) begin n_bad++;
            $display("FAIL async_reset_valid: got %b want 0", bus.IFID_Valid); end
        n_cmp++; if (bus.FetchCount !== 32'h0) begin n_bad++;
            $display("FAIL async_reset_count: got %h want 0", bus.FetchCount); end
        Reset = 1'b1;
        model_reset();
    endtask

    task automatic test_streaming();
        do_reset();
        step(0, 0, 0, 32'h0);
        n_cmp++; if (bus.Imm16 !== 16'h0005) begin n_bad++;
            $display("FAIL stream_imm0: got %h want 0005", bus.Imm16); end
        n_cmp++; if (bus.IFID_PCPlus4 !== 32'h4) begin n_bad++;
            $display("FAIL stream_pcp4_0: got %h want 4", bus.IFID_PCPlus4); end
        step(0, 0, 0, 32'h0);
        n_cmp++; if (bus.Imm16 !== 16'hFFFF) begin n_bad++;
            $display("FAIL stream_imm1: got %h want ffff", bus.Imm16); end
        n_cmp++; if (bus.Rt !== 5'd9) begin n_bad++;
            $display("FAIL stream_rt1: got %0d want 9", bus.Rt); end
        n_cmp++; if (bus.PC !== 32'h8) begin n_bad++;
            $display("FAIL stream_pc: got %h want 8", bus.PC); end
        n_cmp++; if (bus.FetchCount !== 32'd2) begin n_bad++;
            $display("FAIL stream_count: got %0d want 2", bus.FetchCount); end
    endtask

    task automatic test_stall();
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 0, 32'h0);
            n_cmp++; if (bus.ImemAddr !== 32'h8) begin n_bad++;
                $display("FAIL stall_addr: got %h want 8", bus.ImemAddr); end
            n_cmp++; if (bus.IFID_Instr !== 32'h2009_FFFF) begin n_bad++;
                $display("FAIL stall_instr: got %h want 2009ffff", bus.IFID_Instr); end
            n_cmp++; if (bus.FetchCount !== 32'd2) begin n_bad++;
                $display("FAIL stall_count: got %0d want 2", bus.FetchCount); end
        end
        step(0, 0, 0, 32'h0);
        n_cmp++; if (bus.PC !== 32'hC) begin n_bad++;
            $display("FAIL stall_release_pc: got %h want c", bus.PC); end
        n_cmp++; if (bus.IFID_Instr !== imem_word(32'h8)) begin n_bad++;
            $display("FAIL stall_release_instr: got %h want %h", bus.IFID_Instr,
                     imem_word(32'h8)); end
    endtask

    task automatic test_redirect();
        step(0, 0, 0, 32'h0);
        n_cmp++; if (bus.PC !== 32'h10) begin n_bad++;
            $display("FAIL redir_start_pc: got %h want 10", bus.PC); end
        step(0, 0, 1, 32'h0000_0103);
        n_cmp++; if (bus.PC !== 32'h100) begin n_bad++;
            $display("FAIL redir_pc: got %h want 100", bus.PC); end
        n_cmp++; if (bus.IFID_Valid !== 1'b0) begin n_bad++;
            $display("FAIL redir_valid: got %b want 0", bus.IFID_Valid); end
        n_cmp++; if ({bus.Opcode, bus.Rs, bus.Rt, bus.Rd, bus.Shamt, bus.Funct, bus.Imm16,
                      bus.JumpIndex} !== 74'h0) begin n_bad++;
            $display("FAIL redir_fields: got op=%h rs=%h rt=%h rd=%h sh=%h fn=%h imm=%h ji=%h want 0",
                     bus.Opcode, bus.Rs, bus.Rt, bus.Rd, bus.Shamt, bus.Funct, bus.Imm16,
                     bus.JumpIndex); end
        step(0, 0, 0, 32'h0);
        n_cmp++; if (bus.IFID_Instr !== imem_word(32'h100)) begin n_bad++;
            $display("FAIL redir_target_instr: got %h want %h", bus.IFID_Instr,
                     imem_word(32'h100)); end
        n_cmp++; if (bus.IFID_PCPlus4 !== 32'h104) begin n_bad++;
            $display("FAIL redir_target_pcp4: got %h want 104", bus.IFID_PCPlus4); end
    endtask

    task automatic test_simultaneous();
        logic [31:0] cnt;
        step(1, 0, 1, 32'h200);
        n_cmp++; if (bus.PC !== 32'h200) begin n_bad++;
            $display("FAIL stall_redir_pc: got %h want 200", bus.PC); end
        n_cmp++; if (bus.IFID_Valid !== 1'b0) begin n_bad++;
            $display("FAIL stall_redir_valid: got %b want 0", bus.IFID_Valid); end
        step(0, 0, 0, 32'h0);
        cnt = bus.FetchCount;
        step(1, 1, 0, 32'h0);
        n_cmp++; if (bus.PC !== 32'h204) begin n_bad++;
            $display("FAIL stall_flush_pc: got %h want 204", bus.PC); end
        n_cmp++; if (bus.IFID_Valid !== 1'b0) begin n_bad++;
            $display("FAIL stall_flush_valid: got %b want 0", bus.IFID_Valid); end
        n_cmp++; if (bus.FetchCount !== m_cnt || m_cnt !== cnt) begin n_bad++;
            $display("FAIL stall_flush_count: got %0d want %0d", bus.FetchCount, m_cnt); end
    endtask

    task automatic test_wrap();
        step(0, 0, 1, 32'hFFFF_FFFC);
        step(0, 0, 0, 32'h0);
        n_cmp++; if (bus.IFID_PCPlus4 !== 32'h0) begin n_bad++;
            $display("FAIL wrap_pcp4: got %h want 0", bus.IFID_PCPlus4); end
        n_cmp++; if (bus.PC !== 32'h0) begin n_bad++;
            $display("FAIL wrap_pc: got %h want 0", bus.PC); end
    endtask

    task automatic test_reset_mid_stall();
        step(1, 0, 0, 32'h0);
        Reset = 1'b0;
        #1;
        n_cmp++; if (bus.PC !== 32'h0 || bus.IFID_Valid !== 1'b0) begin n_bad++;
            $display("FAIL midstall_reset: got pc=%h valid=%b want 0/0", bus.PC, bus.IFID_Valid);
        end
        bus.Stall = 1'b0;
        Reset = 1'b1;
        model_reset();
        step(0, 0, 0, 32'h0);
        n_cmp++; if (bus.IFID_Instr !== 32'h2008_0005 || bus.PC !== 32'h4) begin n_bad++;
            $display("FAIL midstall_resume: got instr=%h pc=%h want 20080005/4",
                     bus.IFID_Instr, bus.PC); end
    endtask

    task automatic test_random();
        logic s, f, r;
        logic [31:0] ra;
        for (int i = 0; i < 300; i++) begin
            s  = ($urandom_range(0, 3) == 0);
            f  = ($urandom_range(0, 7) == 0);
            r  = ($urandom_range(0, 9) == 0);
            ra = $urandom;
            step(s, f, r, ra);
            n_cmp++; if (bus.PC !== m_pc || bus.ImemAddr !== m_pc) begin n_bad++;
                $display("FAIL rand_pc[%0d]: got %h/%h want %h", i, bus.PC, bus.ImemAddr, m_pc);
            end
            n_cmp++; if (bus.IFID_Instr !== m_instr || bus.IFID_PCPlus4 !== m_pcp4 ||
                         bus.IFID_Valid !== m_valid) begin n_bad++;
                $display("FAIL rand_ifid[%0d]: got %h/%h/%b want %h/%h/%b", i, bus.IFID_Instr,
                         bus.IFID_PCPlus4, bus.IFID_Valid, m_instr, m_pcp4, m_valid); end
            n_cmp++; if (bus.FetchCount !== m_cnt) begin n_bad++;
                $display("FAIL rand_count[%0d]: got %0d want %0d", i, bus.FetchCount, m_cnt); end
            n_cmp++; if (bus.Opcode !== m_instr[31:26] || bus.Rs !== m_instr[25:21] ||
                         bus.Rd !== m_instr[15:11] || bus.Shamt !== m_instr[10:6] ||
                         bus.Funct !== m_instr[5:0] || bus.JumpIndex !== m_instr[25:0]) begin
                n_bad++;
                $display("FAIL rand_fields[%0d]: got op=%h rs=%h rd=%h sh=%h fn=%h want word %h",
                         i, bus.Opcode, bus.Rs, bus.Rd, bus.Shamt, bus.Funct, m_instr); end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        Reset = 1'b0;
        bus.Stall = 1'b0;
        bus.Flush = 1'b0;
        bus.Redirect = 1'b0;
        bus.RedirectAddr = 32'h0;
        model_reset();
        #1;
        test_reset();
        test_streaming();
        test_stall();
        test_redirect();
        test_simultaneous();
        test_wrap();
        test_reset_mid_stall();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
